// File: rtl/bounded_hold_arb_pkg.sv
// Shared types and default timing constants for the bounded-hold arbiter.
package bounded_hold_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_MIN_HOLD   = 2;
  localparam int DEF_MAX_HOLD   = 6;
  localparam int DEF_GAP_CYCLES = 1;
endpackage

// File: rtl/bounded_hold_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping.
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] win_id
);
  logic [IDW-1:0] idx;

  // Scan offsets high-to-low so the smallest offset from ptr is written last.
  always_comb begin
    any    = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        any    = 1'b1;
        win_id = idx;
      end
    end
  end
endmodule

// File: rtl/bounded_hold_arbiter.sv
// Round-robin arbiter whose grants last between MIN_HOLD and MAX_HOLD cycles,
// separated by exactly GAP_CYCLES idle cycles.
module bounded_hold_arbiter
  import bounded_hold_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int MIN_HOLD   = DEF_MIN_HOLD,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W      = $clog2(MAX_HOLD + 1),
  parameter int IDW        = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     rel,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             forced_rel
);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if ((N < 2) || (MIN_HOLD < 1) || (MAX_HOLD < MIN_HOLD) || (GAP_CYCLES < 1)) begin : g_bad_params
    $error("bounded_hold_arbiter: illegal parameters N=%0d MIN_HOLD=%0d MAX_HOLD=%0d GAP_CYCLES=%0d",
           N, MIN_HOLD, MAX_HOLD, GAP_CYCLES);
  end

  state_e         state;
  logic [IDW-1:0] ptr;
  logic [GW-1:0]  gap_cnt;
  logic           any;
  logic [IDW-1:0] win_id;

  rr_picker #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .win_id (win_id)
  );

  logic cur_req, cur_rel, at_max, at_min, release_now, gap_done;
  always_comb begin
    cur_req     = req[gnt_id];
    cur_rel     = rel[gnt_id];
    at_max      = (hold_cnt == CNT_W'(MAX_HOLD));
    at_min      = (hold_cnt >= CNT_W'(MIN_HOLD));
    release_now = at_max || (at_min && (!cur_req || cur_rel));
    gap_done    = (gap_cnt == GW'(GAP_CYCLES));
  end

  // rst_n is active-high in this codebase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      gnt_id     <= '0;
      hold_cnt   <= '0;
      forced_rel <= 1'b0;
      ptr        <= '0;
      gap_cnt    <= '0;
    end else begin
      forced_rel <= 1'b0;
      case (state)
        HOLD: begin
          if (release_now) begin
            gnt        <= '0;
            gnt_valid  <= 1'b0;
            hold_cnt   <= '0;
            gap_cnt    <= GW'(1);
            state      <= GAP;
            forced_rel <= at_max && cur_req && !cur_rel;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (state == GAP && !gap_done) begin
            gap_cnt <= gap_cnt + GW'(1);
          end else if (any) begin
            gnt       <= N'(1) << win_id;
            gnt_valid <= 1'b1;
            gnt_id    <= win_id;
            hold_cnt  <= CNT_W'(1);
            ptr       <= (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
            gap_cnt   <= '0;
            state     <= HOLD;
          end else begin
            gap_cnt <= '0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  a_onehot0: assert property (@(posedge clk) disable iff (rst_n) $onehot0(gnt));
  a_hold_range: assert property (@(posedge clk) disable iff (rst_n)
    gnt_valid |-> (hold_cnt >= CNT_W'(1) && hold_cnt <= CNT_W'(MAX_HOLD)));
  a_min_hold: assert property (@(posedge clk) disable iff (rst_n)
    $fell(gnt_valid) |-> ($past(hold_cnt) >= CNT_W'(MIN_HOLD)));
  a_forced_idle: assert property (@(posedge clk) disable iff (rst_n)
    forced_rel |-> (hold_cnt == '0));
endmodule

// File: tb/tb_bounded_hold_arbiter.sv
// Directed plus random bench for bounded_hold_arbiter against a rule-level model.
module tb_bounded_hold_arbiter;
  localparam int N = 4, MINH = 2, MAXH = 6, GAPC = 1;
  localparam int CNT_W = $clog2(MAXH + 1), IDW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req, rel;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_id;
  logic [CNT_W-1:0] hold_cnt;
  logic             forced_rel;

  bounded_hold_arbiter #(.N(N), .MIN_HOLD(MINH), .MAX_HOLD(MAXH), .GAP_CYCLES(GAPC),
                         .CNT_W(CNT_W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .hold_cnt(hold_cnt), .forced_rel(forced_rel)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model: who owns the resource, for how long, how many gap cycles remain.
  int m_owner, m_held, m_gapleft, m_last, m_next;
  bit m_forced;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_gapleft = 0; m_last = 0; m_next = 0; m_forced = 0;
  endtask

  task automatic model_step();
    if (m_owner >= 0) begin
      bit r = req[m_owner], q = rel[m_owner];
      if (m_held == MAXH || (m_held >= MINH && (!r || q))) begin
        m_forced  = (m_held == MAXH) && r && !q;
        m_owner   = -1;
        m_held    = 0;
        m_gapleft = GAPC;
      end else begin
        m_forced = 0;
        m_held++;
      end
    end else begin
      m_forced = 0;
      if (m_gapleft > 1) m_gapleft--;
      else begin
        m_gapleft = 0;
        for (int k = 0; k < N; k++) begin
          int i = (m_next + k) % N;
          if (req[i]) begin
            m_owner = i; m_held = 1; m_last = i; m_next = (i + 1) % N;
            break;
          end
        end
      end
    end
  endtask

  task automatic cmp_all(input string ph);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({ph, ".gnt"}, 32'(gnt), 32'(eg));
    chk({ph, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({ph, ".gnt_id"}, 32'(gnt_id), 32'(m_last));
    chk({ph, ".hold_cnt"}, 32'(hold_cnt), 32'(m_held));
    chk({ph, ".forced_rel"}, 32'(forced_rel), 32'(m_forced));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_step();
    #1;
    cmp_all(ph);
  endtask

  // Waits (bounded) for the next grant and returns wait and high lengths.
  task automatic measure(input string ph, output int wait_c, output int len);
    wait_c = 0;
    while (!gnt_valid && wait_c < 20) begin step(ph); wait_c++; end
    len = 0;
    while (gnt_valid && len < 20) begin step(ph); len++; end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, len, run;
    rst_n = 1'b1; req = '0; rel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 cmp_all("reset");
    @(negedge clk) rst_n = 1'b0;

    // 1: single-cycle request still gets MIN_HOLD
    req = 4'b0001;
    step("t1");
    len = gnt[0] ? 1 : 0;
    req = '0;
    repeat (8) begin step("t1"); if (gnt[0]) len++; end
    chk("t1_len", 32'(len), 32'(MINH));

    // 2: continuous request is cut at MAX_HOLD, forced_rel in the gap
    req = 4'b0010;
    for (int rep = 0; rep < 3; rep++) begin
      measure("t2", w, len);
      chk("t2_len", 32'(len), 32'(MAXH));
      chk("t2_forced", 32'(forced_rel), 32'd1);
      if (rep > 0) chk("t2_gap", 32'(w), 32'(GAPC));
    end
    req = '0;
    repeat (10) step("t2_drain");

    // 3: two requesters held from reset alternate
    rst_n = 1'b1; req = 4'b0101;
    model_reset();
    #1 cmp_all("t3_rst");
    @(negedge clk) rst_n = 1'b0;
    measure("t3", w, len);
    chk("t3_len_a", 32'(len), 32'(MAXH)); chk("t3_id_a", 32'(gnt_id), 32'd0);
    measure("t3", w, len);
    chk("t3_len_b", 32'(len), 32'(MAXH)); chk("t3_id_b", 32'(gnt_id), 32'd2);
    measure("t3", w, len);
    chk("t3_len_c", 32'(len), 32'(MAXH)); chk("t3_id_c", 32'(gnt_id), 32'd0);

    // 4: early release by the grantee
    req = 4'b1000;
    w = 0;
    while (gnt_valid && w < 20) begin step("t4"); w++; end
    while (!gnt_valid && w < 40) begin step("t4"); w++; end
    len = 0;
    while (gnt_valid && len < 20) begin
      len++;
      rel = (hold_cnt == 3) ? 4'b1000 : 4'b0000;
      step("t4a");
    end
    rel = '0;
    chk("t4_len3", 32'(len), 32'd3); chk("t4_forced3", 32'(forced_rel), 32'd0);
    chk("t4_id", 32'(gnt_id), 32'd3);
    w = 0;
    while (!gnt_valid && w < 20) begin step("t4"); w++; end
    len = 0;
    while (gnt_valid && len < 20) begin
      len++;
      rel = (hold_cnt >= 1) ? 4'b1000 : 4'b0000;
      step("t4b");
    end
    rel = '0;
    chk("t4_len2", 32'(len), 32'(MINH)); chk("t4_forced2", 32'(forced_rel), 32'd0);

    // 5: asynchronous reset mid-grant, then pointer restarts at 0
    req = 4'b0001;
    w = 0;
    while (hold_cnt != CNT_W'(4) && w < 40) begin step("t5"); w++; end
    chk("t5_reached4", 32'(hold_cnt), 32'd4);
    #2 rst_n = 1'b1;
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'd0);
    chk("t5_async_valid", 32'(gnt_valid), 32'd0);
    chk("t5_async_cnt", 32'(hold_cnt), 32'd0);
    model_reset();
    req = 4'b0110;
    @(negedge clk) rst_n = 1'b0;
    step("t5_post");
    chk("t5_first_id", 32'(gnt_id), 32'd1);
    req = '0;
    repeat (10) step("t5_drain");

    // 6: one-edge latency from IDLE, then random traffic
    req = 4'b0100;
    step("t6_lat");
    chk("t6_latency", 32'(gnt), 32'b0100);
    run = 1;
    for (int i = 0; i < 10000; i++) begin
      req = N'($urandom);
      rel = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step("t6_rand");
      chk("t6_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (gnt_valid) run++;
      else begin
        if (run > 0) chk("t6_duration", 32'(run >= MINH && run <= MAXH), 32'd1);
        run = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
